decode_stage: RTL and testbench

//   Registered RV32I decode/control stage between fetch and execute.

---
 rtl/decode_stage_if.sv | 51 +++++
 rtl/decode_stage.sv | 269 ++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// decode_stage_if
//   Handshake and decoded-bundle signals between fetch, the decode stage and
//   execute.
//   master : fetch/execute side (drives flush, in_*, out_ready)
//   slave  : decode stage (drives in_ready, out_* and the decoded bundle)
// -----------------------------------------------------------------------------
interface decode_stage_if #(
    parameter int XLEN      = 32,
    parameter int ILL_CNT_W = 8
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_ins;
    logic [XLEN-1:0]      in_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_pc;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [XLEN-1:0]      imm;
    logic                 alu_imm;
    logic [2:0]           alu_op;
    logic                 alu_alt;
    logic                 reg_wen;
    logic                 mem_rd;
    logic                 mem_wr;
    logic [2:0]           mem_size;
    logic                 branch;
    logic                 br_inv;
    logic                 jump;
    logic                 mul_en;
    logic                 illegal;
    logic [ILL_CNT_W-1:0] ill_cnt;

    modport master (
        output flush, in_valid, in_ins, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, rs1, rs2, rd, imm, alu_imm, alu_op,
               alu_alt, reg_wen, mem_rd, mem_wr, mem_size, branch, br_inv,
               jump, mul_en, illegal, ill_cnt
    );

    modport slave (
        input  flush, in_valid, in_ins, in_pc, out_ready,
        output in_ready, out_valid, out_pc, rs1, rs2, rd, imm, alu_imm, alu_op,
               alu_alt, reg_wen, mem_rd, mem_wr, mem_size, branch, br_inv,
               jump, mul_en, illegal, ill_cnt
    );
endinterface

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Registered RV32I decode/control stage between fetch and execute with a
//   valid/ready handshake and a 2-entry (main + skid) buffer.
//   Optional feature macro: DECODE_RV32M_EN (accept M-extension OP encodings).
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : decode_stage_if.slave -- flush, in_valid/in_ready/in_ins/in_pc,
//            out_valid/out_ready, decoded bundle (out_pc, rs1, rs2, rd, imm,
//            alu_imm, alu_op, alu_alt, reg_wen, mem_rd, mem_wr, mem_size,
//            branch, br_inv, jump, mul_en, illegal) and ill_cnt
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int ILL_CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [ILL_CNT_W-1:0] ILL_MAX = '1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            alu_imm;
        logic [2:0]      alu_op;
        logic            alu_alt;
        logic            reg_wen;
        logic            mem_rd;
        logic            mem_wr;
        logic [2:0]      mem_size;
        logic            branch;
        logic            br_inv;
        logic            jump;
        logic            mul_en;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    logic [31:0]          ins_s;
    logic [6:0]           opcode_s;
    logic [2:0]           funct3_s;
    logic [6:0]           funct7_s;
    logic [31:0]          imm32_s;
    logic                 ill_s;
    bundle_t              dec_s;
    logic                 accept_s;
    logic                 pop_s;

    state_t               state_r;
    bundle_t              main_r;
    bundle_t              skid_r;
    logic                 out_valid_r;
    logic                 in_ready_r;
    logic [ILL_CNT_W-1:0] ill_cnt_r;

    assign ins_s    = bus.in_ins;
    assign opcode_s = ins_s[6:0];
    assign funct3_s = ins_s[14:12];
    assign funct7_s = ins_s[31:25];
    assign accept_s = bus.in_valid & in_ready_r;
    assign pop_s    = out_valid_r & bus.out_ready;

    // Combinational decode of the offered instruction word into a bundle.
    always_comb begin
        dec_s     = '0;
        imm32_s   = 32'd0;
        ill_s     = 1'b0;
        dec_s.pc  = bus.in_pc;
        dec_s.rs1 = ins_s[19:15];
        dec_s.rs2 = ins_s[24:20];
        dec_s.rd  = ins_s[11:7];
        case (opcode_s)
            OPC_LUI: begin
                imm32_s       = {ins_s[31:12], 12'd0};
                dec_s.rs1     = 5'd0;   // LUI computes 0 + imm
                dec_s.alu_imm = 1'b1;
                dec_s.reg_wen = 1'b1;
            end
            OPC_AUIPC: begin
                imm32_s       = {ins_s[31:12], 12'd0};
                dec_s.alu_imm = 1'b1;
                dec_s.reg_wen = 1'b1;
            end
            OPC_JAL: begin
                imm32_s       = {{12{ins_s[31]}}, ins_s[19:12], ins_s[20], ins_s[30:21], 1'b0};
                dec_s.alu_imm = 1'b1;
                dec_s.reg_wen = 1'b1;
                dec_s.jump    = 1'b1;
            end
            OPC_JALR: begin
                imm32_s       = {{20{ins_s[31]}}, ins_s[31:20]};
                dec_s.alu_imm = 1'b1;
                dec_s.reg_wen = 1'b1;
                dec_s.jump    = 1'b1;
                ill_s         = (funct3_s != 3'b000);
            end
            OPC_BRANCH: begin
                imm32_s      = {{20{ins_s[31]}}, ins_s[7], ins_s[30:25], ins_s[11:8], 1'b0};
                dec_s.branch = 1'b1;
                // Equality uses SUB, ordering uses SLT/SLTU; br_inv selects "taken on zero".
                case (funct3_s)
                    3'b000:  begin dec_s.alu_alt = 1'b1; dec_s.br_inv = 1'b1; end
                    3'b001:  begin dec_s.alu_alt = 1'b1; end
                    3'b100:  begin dec_s.alu_op = 3'b010; end
                    3'b101:  begin dec_s.alu_op = 3'b010; dec_s.br_inv = 1'b1; end
                    3'b110:  begin dec_s.alu_op = 3'b011; end
                    3'b111:  begin dec_s.alu_op = 3'b011; dec_s.br_inv = 1'b1; end
                    default: begin ill_s = 1'b1; end
                endcase
            end
            OPC_LOAD: begin
                imm32_s        = {{20{ins_s[31]}}, ins_s[31:20]};
                dec_s.alu_imm  = 1'b1;
                dec_s.reg_wen  = 1'b1;
                dec_s.mem_rd   = 1'b1;
                dec_s.mem_size = funct3_s;
                ill_s          = (funct3_s == 3'b011) || (funct3_s[2:1] == 2'b11);
            end
            OPC_STORE: begin
                imm32_s        = {{20{ins_s[31]}}, ins_s[31:25], ins_s[11:7]};
                dec_s.alu_imm  = 1'b1;
                dec_s.mem_wr   = 1'b1;
                dec_s.mem_size = funct3_s;
                ill_s          = (funct3_s > 3'b010);
            end
            OPC_OPIMM: begin
                imm32_s       = {{20{ins_s[31]}}, ins_s[31:20]};
                dec_s.alu_imm = 1'b1;
                dec_s.reg_wen = 1'b1;
                dec_s.alu_op  = funct3_s;
                dec_s.alu_alt = (funct3_s == 3'b101) ? ins_s[30] : 1'b0;
                case (funct3_s)
                    3'b001:  ill_s = (funct7_s != 7'b0000000);
                    3'b101:  ill_s = (funct7_s != 7'b0000000) && (funct7_s != 7'b0100000);
                    default: ill_s = 1'b0;
                endcase
            end
            OPC_OP: begin
                dec_s.reg_wen = 1'b1;
                dec_s.alu_op  = funct3_s;
                case (funct7_s)
                    7'b0000000: dec_s.alu_alt = 1'b0;
                    7'b0100000: begin
                        dec_s.alu_alt = 1'b1;
                        ill_s = (funct3_s != 3'b000) && (funct3_s != 3'b101);
                    end
`ifdef DECODE_RV32M_EN
                    7'b0000001: dec_s.mul_en = 1'b1;
`else
                    7'b0000001: ill_s = 1'b1;
`endif
                    default:    ill_s = 1'b1;
                endcase
            end
            default: ill_s = 1'b1;
        endcase
        ill_s     = ill_s | (ins_s[1:0] != 2'b11);
        dec_s.imm = XLEN'(signed'(imm32_s));
        // Illegal words still flow downstream but must cause no side effects.
        if (ill_s) begin
            dec_s.illegal = 1'b1;
            dec_s.reg_wen = 1'b0;
            dec_s.mem_rd  = 1'b0;
            dec_s.mem_wr  = 1'b0;
            dec_s.branch  = 1'b0;
            dec_s.jump    = 1'b0;
            dec_s.mul_en  = 1'b0;
        end else begin
            dec_s.illegal = 1'b0;
        end
    end

    // Buffer FSM: main/skid entries, registered out_valid and in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            main_r      <= '0;
            skid_r      <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (bus.flush) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_r      <= dec_s;
                        state_r     <= ST_ONE;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        main_r <= dec_s;
                    end else if (accept_s) begin
                        // Main is stalled, so the newcomer parks in skid.
                        skid_r     <= dec_s;
                        state_r    <= ST_FULL;
                        in_ready_r <= 1'b0;
                    end else if (pop_s) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        main_r     <= skid_r;
                        state_r    <= ST_ONE;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    // Saturating count of accepted illegal words, including ones dropped by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt_r <= '0;
        end else if (accept_s && dec_s.illegal && (ill_cnt_r != ILL_MAX)) begin
            ill_cnt_r <= ill_cnt_r + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_pc    = main_r.pc;
    assign bus.rs1       = main_r.rs1;
    assign bus.rs2       = main_r.rs2;
    assign bus.rd        = main_r.rd;
    assign bus.imm       = main_r.imm;
    assign bus.alu_imm   = main_r.alu_imm;
    assign bus.alu_op    = main_r.alu_op;
    assign bus.alu_alt   = main_r.alu_alt;
    assign bus.reg_wen   = main_r.reg_wen;
    assign bus.mem_rd    = main_r.mem_rd;
    assign bus.mem_wr    = main_r.mem_wr;
    assign bus.mem_size  = main_r.mem_size;
    assign bus.branch    = main_r.branch;
    assign bus.br_inv    = main_r.br_inv;
    assign bus.jump      = main_r.jump;
    assign bus.mul_en    = main_r.mul_en;
    assign bus.illegal   = main_r.illegal;
    assign bus.ill_cnt   = ill_cnt_r;
endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Directed-vector bench for decode_stage with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_decode_stage;
    localparam int XLEN      = 32;
    localparam int ILL_CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   check_cnt = 0;
    int   err_cnt   = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(XLEN), .ILL_CNT_W(ILL_CNT_W)) bus_if ();

    decode_stage #(.XLEN(XLEN), .ILL_CNT_W(ILL_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        bus_if.in_valid = 1'b1;
        bus_if.in_ins   = ins;
        bus_if.in_pc    = pc;
        tick();
        bus_if.in_valid = 1'b0;
    endtask

    // ADDI rd, x0, rd : imm and rd both equal r
    function automatic logic [31:0] addi_enc(input logic [4:0] r);
        return {7'd0, r, 5'd0, 3'b000, r, 7'b0010011};
    endfunction

    initial begin
        rst_n            = 1'b0;
        bus_if.flush     = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_ins    = 32'd0;
        bus_if.in_pc     = 32'd0;
        bus_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", bus_if.out_valid, 64'd0);
        check_val("rst_in_ready",  bus_if.in_ready,  64'd1);
        check_val("rst_ill_cnt",   bus_if.ill_cnt,   64'd0);
        check_val("rst_imm",       bus_if.imm,       64'd0);
        rst_n = 1'b1;
        tick();

        // ADDI x1,x0,-1
        send(32'hFFF00093, 32'h0000_0100);
        check_val("addi_valid",   bus_if.out_valid, 64'd1);
        check_val("addi_alu_imm", bus_if.alu_imm,   64'd1);
        check_val("addi_alu_op",  bus_if.alu_op,    64'd0);
        check_val("addi_alu_alt", bus_if.alu_alt,   64'd0);
        check_val("addi_imm",     bus_if.imm,       64'hFFFF_FFFF);
        check_val("addi_rd",      bus_if.rd,        64'd1);
        check_val("addi_reg_wen", bus_if.reg_wen,   64'd1);
        check_val("addi_pc",      bus_if.out_pc,    64'h100);

        // BGEU x1,x2,+8
        send(32'h0020F463, 32'h0000_0104);
        check_val("bgeu_branch",  bus_if.branch,  64'd1);
        check_val("bgeu_alu_op",  bus_if.alu_op,  64'd3);
        check_val("bgeu_br_inv",  bus_if.br_inv,  64'd1);
        check_val("bgeu_imm",     bus_if.imm,     64'd8);
        check_val("bgeu_reg_wen", bus_if.reg_wen, 64'd0);
        check_val("bgeu_alu_imm", bus_if.alu_imm, 64'd0);

        // SUB x5,x6,x7
        send(32'h407302B3, 32'h0000_0108);
        check_val("sub_alt",  bus_if.alu_alt, 64'd1);
        check_val("sub_op",   bus_if.alu_op,  64'd0);
        check_val("sub_rs2",  bus_if.rs2,     64'd7);
        check_val("sub_rd",   bus_if.rd,      64'd5);

        // LW x3,12(x2)
        send(32'h00C12183, 32'h0000_010C);
        check_val("lw_mem_rd", bus_if.mem_rd,   64'd1);
        check_val("lw_size",   bus_if.mem_size, 64'd2);
        check_val("lw_imm",    bus_if.imm,      64'd12);

        // SW x5,-4(x2)
        send(32'hFE512E23, 32'h0000_0110);
        check_val("sw_mem_wr",  bus_if.mem_wr,  64'd1);
        check_val("sw_imm",     bus_if.imm,     64'hFFFF_FFFC);
        check_val("sw_reg_wen", bus_if.reg_wen, 64'd0);

        // LUI x7,0x12345
        send(32'h123453B7, 32'h0000_0114);
        check_val("lui_imm", bus_if.imm, 64'h1234_5000);
        check_val("lui_rs1", bus_if.rs1, 64'd0);

        // JAL x1,+16
        send(32'h010000EF, 32'h0000_0118);
        check_val("jal_jump", bus_if.jump, 64'd1);
        check_val("jal_imm",  bus_if.imm,  64'd16);
        tick();
        check_val("drain_valid", bus_if.out_valid, 64'd0);

        // Back-pressure: two accepted, third refused, then in-order release
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.in_ins    = addi_enc(5'd10);
        tick();
        check_val("bp1_in_ready", bus_if.in_ready, 64'd1);
        check_val("bp1_rd",       bus_if.rd,       64'd10);
        bus_if.in_ins = addi_enc(5'd11);
        tick();
        check_val("bp2_in_ready", bus_if.in_ready, 64'd0);
        check_val("bp2_rd_hold",  bus_if.rd,       64'd10);
        bus_if.in_ins = addi_enc(5'd12);
        tick();
        check_val("bp3_rd_hold",  bus_if.rd,       64'd10);
        check_val("bp3_imm_hold", bus_if.imm,      64'd10);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        tick();
        check_val("rel1_rd",    bus_if.rd,        64'd11);
        check_val("rel1_valid", bus_if.out_valid, 64'd1);
        tick();
        check_val("rel2_valid", bus_if.out_valid, 64'd0);

        // Illegal instructions and counter saturation
        send(32'h00000000, 32'h0000_0200);
        check_val("ill_flag",    bus_if.illegal, 64'd1);
        check_val("ill_reg_wen", bus_if.reg_wen, 64'd0);
        check_val("ill_mem_rd",  bus_if.mem_rd,  64'd0);
        check_val("ill_mem_wr",  bus_if.mem_wr,  64'd0);
        check_val("ill_branch",  bus_if.branch,  64'd0);
        check_val("ill_jump",    bus_if.jump,    64'd0);
        check_val("ill_mul_en",  bus_if.mul_en,  64'd0);
        check_val("ill_cnt_1",   bus_if.ill_cnt, 64'd1);
        bus_if.in_valid = 1'b1;
        bus_if.in_ins   = 32'hFFFFFFFF;
        repeat (254) tick();
        check_val("ill_cnt_255", bus_if.ill_cnt, 64'd255);
        tick();
        check_val("ill_cnt_sat", bus_if.ill_cnt, 64'd255);
        bus_if.in_valid = 1'b0;
        send(32'h00001067, 32'h0000_0300);   // JALR funct3=001
        check_val("jalr_f3_ill",  bus_if.illegal, 64'd1);
        check_val("jalr_f3_jump", bus_if.jump,    64'd0);
        send(32'h00002063, 32'h0000_0304);   // BRANCH funct3=010
        check_val("br_f3_ill",    bus_if.illegal, 64'd1);
        check_val("br_f3_branch", bus_if.branch,  64'd0);
        check_val("ill_cnt_hold", bus_if.ill_cnt, 64'd255);

        // MUL x3,x1,x2
        send(32'h022081B3, 32'h0000_0308);
`ifdef DECODE_RV32M_EN
        check_val("mul_en",      bus_if.mul_en,  64'd1);
        check_val("mul_alu_op",  bus_if.alu_op,  64'd0);
        check_val("mul_reg_wen", bus_if.reg_wen, 64'd1);
        check_val("mul_illegal", bus_if.illegal, 64'd0);
`else
        check_val("mul_illegal", bus_if.illegal, 64'd1);
        check_val("mul_reg_wen", bus_if.reg_wen, 64'd0);
        check_val("mul_en",      bus_if.mul_en,  64'd0);
`endif
        tick();

        // Flush from FULL
        bus_if.out_ready = 1'b0;
        send(addi_enc(5'd1), 32'h0000_0400);
        send(addi_enc(5'd2), 32'h0000_0404);
        check_val("full_in_ready",   bus_if.in_ready,  64'd0);
        check_val("full_out_valid",  bus_if.out_valid, 64'd1);
        bus_if.flush    = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.in_ins   = addi_enc(5'd3);
        tick();
        bus_if.flush    = 1'b0;
        bus_if.in_valid = 1'b0;
        check_val("flush_out_valid", bus_if.out_valid, 64'd0);
        check_val("flush_in_ready",  bus_if.in_ready,  64'd1);

        // Flush drops a same-cycle acceptance from EMPTY
        bus_if.flush = 1'b1;
        send(addi_enc(5'd3), 32'h0000_0408);
        bus_if.flush = 1'b0;
        check_val("flush_drop_valid", bus_if.out_valid, 64'd0);

        // Asynchronous reset mid-stream
        send(addi_enc(5'd4), 32'h0000_040C);
        check_val("pre_rst_valid", bus_if.out_valid, 64'd1);
        check_val("pre_rst_rd",    bus_if.rd,        64'd4);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", bus_if.out_valid, 64'd0);
        check_val("arst_in_ready",  bus_if.in_ready,  64'd1);
        check_val("arst_ill_cnt",   bus_if.ill_cnt,   64'd0);
        check_val("arst_rd",        bus_if.rd,        64'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end
endmodule
